// File: rtl/uart_pkg.sv
// Types and codes shared between the UART debug TAP and the DMI handler.
package uart_pkg;

    localparam logic [1:0] DTM_NOP   = 2'h0;
    localparam logic [1:0] DTM_READ  = 2'h1;
    localparam logic [1:0] DTM_WRITE = 2'h2;

    localparam logic [1:0] DMINoError = 2'h0;
    localparam logic [1:0] DMIFailed  = 2'h2;
    localparam logic [1:0] DMIBusy    = 2'h3;

    // op doubles as the response code on the read-back path, so it is a plain 2-bit field
    typedef struct packed {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

// File: rtl/dmi_handler.sv
// Bridges TAP read/write strobes to a valid/ready DMI request/response pair.
// Optional response watchdog enabled by defining DMI_HANDLER_TIMEOUT_EN.
module dmi_handler
    import uart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         CLK_I,
    input  logic                         RST_NI,
    input  logic                         DMI_READ_I,
    input  logic                         DMI_WRITE_I,
    input  logic [$bits(dmi_req_t)-1:0]  DMI_I,
    output logic [$bits(dmi_req_t)-1:0]  DMI_O,
    output logic                         DMI_DONE_O,
    output logic [1:0]                   DMI_ERROR_O,
    input  logic                         DMI_ERROR_CLR_I,
    output logic                         DMI_REQ_VALID_O,
    input  logic                         DMI_REQ_READY_I,
    output logic [$bits(dmi_req_t)-1:0]  DMI_REQ_O,
    input  logic                         DMI_RESP_VALID_I,
    output logic                         DMI_RESP_READY_O,
    input  logic [$bits(dmi_resp_t)-1:0] DMI_RESP_I
);

    typedef enum logic [1:0] {st_idle, st_req, st_resp, st_done} state_e;

    state_e    state_q;
    dmi_req_t  req_q, out_q;
    logic      valid_q, ready_q, done_q;
    logic [1:0] err_q, err_d;

    dmi_req_t  dmi_in;
    dmi_resp_t resp_in;
    logic [1:0] unused_op;
    logic      req_xfer, resp_xfer, timeout_hit, timeout_fire;

    assign dmi_in    = dmi_req_t'(DMI_I);
    assign resp_in   = dmi_resp_t'(DMI_RESP_I);
    assign unused_op = dmi_in.op;

    assign req_xfer  = (state_q == st_req)  && DMI_REQ_READY_I;
    assign resp_xfer = (state_q == st_resp) && DMI_RESP_VALID_I;

`ifdef DMI_HANDLER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    assign timeout_hit = ((state_q == st_req) || (state_q == st_resp)) &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
`endif

    // A handshake landing on the watchdog's last cycle still completes normally
    assign timeout_fire = timeout_hit && !req_xfer && !resp_xfer;

    // Clear first, then let a same-cycle error overwrite it; first error sticks otherwise
    always_comb begin
        err_d = DMI_ERROR_CLR_I ? DMINoError : err_q;
        if (resp_xfer && (resp_in.resp != DMINoError) && (err_d == DMINoError))
            err_d = resp_in.resp;
        if (timeout_fire && (err_d == DMINoError))
            err_d = DMIBusy;
    end

    always_ff @(posedge CLK_I) begin
        if (!RST_NI) begin
            state_q <= st_idle;
            req_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
`ifdef DMI_HANDLER_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            err_q <= err_d;
            case (state_q)
                st_idle: begin
                    if (DMI_READ_I) begin
                        req_q   <= '{addr: dmi_in.addr, op: DTM_READ, data: 32'h0};
                        valid_q <= 1'b1;
                        state_q <= st_req;
                    end else if (DMI_WRITE_I) begin
                        req_q   <= '{addr: dmi_in.addr, op: DTM_WRITE, data: dmi_in.data};
                        valid_q <= 1'b1;
                        state_q <= st_req;
                    end
`ifdef DMI_HANDLER_TIMEOUT_EN
                    cnt_q <= '0;
`endif
                end
                st_req: begin
                    if (DMI_REQ_READY_I) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= st_resp;
                    end else if (timeout_hit) begin
                        valid_q <= 1'b0;
                        out_q   <= '{addr: req_q.addr, op: DMIBusy, data: 32'h0};
                        done_q  <= 1'b1;
                        state_q <= st_done;
                    end
`ifdef DMI_HANDLER_TIMEOUT_EN
                    cnt_q <= DMI_REQ_READY_I ? '0 : cnt_q + 1'b1;
`endif
                end
                st_resp: begin
                    if (DMI_RESP_VALID_I) begin
                        ready_q <= 1'b0;
                        out_q   <= '{addr: req_q.addr, op: resp_in.resp, data: resp_in.data};
                        // TAP gave up waiting: swallow the response silently
                        if (DMI_READ_I || DMI_WRITE_I) begin
                            done_q  <= 1'b1;
                            state_q <= st_done;
                        end else begin
                            state_q <= st_idle;
                        end
                    end else if (timeout_hit) begin
                        ready_q <= 1'b0;
                        out_q   <= '{addr: req_q.addr, op: DMIBusy, data: 32'h0};
                        done_q  <= 1'b1;
                        state_q <= st_done;
                    end
`ifdef DMI_HANDLER_TIMEOUT_EN
                    cnt_q <= cnt_q + 1'b1;
`endif
                end
                st_done: begin
                    if (!DMI_READ_I && !DMI_WRITE_I) begin
                        done_q  <= 1'b0;
                        state_q <= st_idle;
                    end
                end
                default: state_q <= st_idle;
            endcase
        end
    end

    assign DMI_O            = out_q;
    assign DMI_REQ_O        = req_q;
    assign DMI_DONE_O       = done_q;
    assign DMI_ERROR_O      = err_q;
    assign DMI_REQ_VALID_O  = valid_q;
    assign DMI_RESP_READY_O = ready_q;

endmodule

// File: doc/dmi_handler.md
DMI_HANDLER -- requirements
Module: dmi_handler

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1024, the response watchdog limit in clock cycles; it is used only when DMI_HANDLER_TIMEOUT_EN is defined.
REQ-002 Port: CLK_I  in  1  system clock; the one clock of the block, all logic on posedge.
REQ-003 Port: RST_NI  in  1  reset; synchronous, active-low.
REQ-004 Port: DMI_READ_I  in  1  read strobe from the UART TAP, held until DMI_DONE_O is seen.
REQ-005 Port: DMI_WRITE_I  in  1  write strobe from the UART TAP, held until DMI_DONE_O is seen.
REQ-006 Port: DMI_I  in  $bits(dmi_req_t)  request from the TAP; only the addr and data fields are used.
REQ-007 Port: DMI_O  out  $bits(dmi_req_t)  read result to the TAP: addr = latched address, data = response data, op = response code.
REQ-008 Port: DMI_DONE_O  out  1  operation complete.
REQ-009 Port: DMI_ERROR_O  out  2  sticky DMI error code: 0 = none, 2 = failed, 3 = busy.
REQ-010 Port: DMI_ERROR_CLR_I  in  1  clears DMI_ERROR_O; driven by dtmcs.dmireset.
REQ-011 Port: DMI_REQ_VALID_O  out  1  request valid towards the debug module.
REQ-012 Port: DMI_REQ_READY_I  in  1  debug module accepts the request.
REQ-013 Port: DMI_REQ_O  out  $bits(dmi_req_t)  request to the debug module.
REQ-014 Port: DMI_RESP_VALID_I  in  1  response valid from the debug module.
REQ-015 Port: DMI_RESP_READY_O  out  1  handler accepts the response.
REQ-016 Port: DMI_RESP_I  in  $bits(dmi_resp_t)  response from the debug module: data and resp.

Function
REQ-017 The block SHALL run an FSM with the states st_idle, st_req, st_resp and st_done; all outputs SHALL be registered.
REQ-018 st_idle: if DMI_READ_I=1, the block SHALL latch addr, set op=DTM_READ and data=0, and go to st_req. If only DMI_WRITE_I=1, it SHALL latch addr and data, set op=DTM_WRITE, and go to st_req. When both strobes are high, read SHALL win.
REQ-019 st_req: DMI_REQ_VALID_O=1 with DMI_REQ_O stable. The request transfers on a cycle where VALID=1 and DMI_REQ_READY_I=1; the block SHALL then go to st_resp.
REQ-020 st_resp: DMI_RESP_READY_O=1. The response transfers on a cycle where DMI_RESP_VALID_I=1. On transfer the block SHALL:
- capture resp.data into DMI_O.data and resp.resp into DMI_O.op;
- set DMI_ERROR_O to resp.resp when resp.resp≠0 and DMI_ERROR_O=0 (first error sticks);
- go to st_done.
REQ-021 st_done: DMI_DONE_O=1. The block SHALL return to st_idle on the first cycle where both strobes are 0, with DMI_DONE_O=0 from that next cycle.
REQ-022 A strobe dropped before completion (TAP timeout) SHALL NOT abort an issued handshake. On response transfer with both strobes low, the block SHALL go directly to st_idle without asserting DONE.
REQ-023 Minimum latency: strobe sampled at cycle n, DMI_REQ_VALID_O at n+1, DMI_DONE_O at n+3 (ready and valid immediate).
REQ-024 DMI_O SHALL hold its value until the next response transfer.
REQ-025 DMI_ERROR_CLR_I=1 SHALL zero DMI_ERROR_O on the next edge; an error arriving in the same cycle SHALL win.

Reset
REQ-026 RST_NI=0 at any point SHALL force the state to st_idle and clear every output to 0 (VALID, READY, DONE, DMI_O, DMI_REQ_O, DMI_ERROR_O). An in-flight request SHALL be dropped.

Configuration
REQ-027 Macro DMI_HANDLER_TIMEOUT_EN, when defined, SHALL add a watchdog counter with these rules:
- it counts cycles in st_req and st_resp and clears on state entry;
- on reaching TIMEOUT_CYCLES the block SHALL set DMI_ERROR_O=3 (if it was 0), set DMI_O.op=3 and DMI_O.data=0, deassert VALID and READY, and go to st_done.
REQ-028 Without DMI_HANDLER_TIMEOUT_EN, the block SHALL have no counter and SHALL wait indefinitely.

Structure
REQ-029 The following SHALL reside in uart_pkg, shared with the TAP: dmi_req_t, dmi_resp_t, DTM_READ/DTM_WRITE/DTM_NOP, and the DMI error codes (DMINoError, DMIBusy, DMIFailed).
REQ-030 The block SHALL be a single module with no sub-module.

Verification
REQ-031 Read, immediate ready: READ_I=1, DMI_I.addr=0x11, DM responds data=0xDEADBEEF resp=0 -> REQ_O.op=DTM_READ addr=0x11; DONE at n+3; DMI_O.data=0xDEADBEEF, op=0; ERROR_O=0.
REQ-032 Write with 3-cycle READY stall: WRITE_I=1, addr=0x10, data=0x00000001 -> VALID and REQ_O held stable for 4 cycles; op=DTM_WRITE; DONE after the response; return to idle one cycle after the strobe falls.
REQ-033 Error stickiness: read with resp=3, then read with resp=2 -> ERROR_O=3 after both; CLR_I pulse -> 0; a third read with resp=2 -> 2.
REQ-034 Abort: READ_I dropped while in st_resp, response arrives 5 cycles later -> DONE never asserted; state st_idle; next read is served correctly.
REQ-035 Reset in st_resp: RST_NI=0 for 1 cycle -> all outputs 0 on the next edge; a late DMI_RESP_VALID_I is ignored.
REQ-036 With DMI_HANDLER_TIMEOUT_EN and TIMEOUT_CYCLES=16, DM never ready -> after 16 cycles VALID=0, DONE=1, DMI_O.op=3, ERROR_O=3.
